// File: rtl/iomem_initiator.sv
// iomem bus initiator: runs one read or fill-write command of 1-256 beats
// on the iomem valid/ready bus, with a per-beat timeout. Read data is
// buffered in a small FIFO for a downstream consumer.
// Ports:
//   clk, resetn             clock, async active-low reset
//   cmd_*                   command channel (valid/ready, write, addr, incr,
//                           count = beats-1, wdata, wstrb)
//   iomem_*                 bus master signals
//   rd_valid/rd_ready/rd_data  read-data FIFO output
//   done, timeout, busy     command status
module iomem_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic        cmd_incr,
  input  logic [7:0]  cmd_count,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        iomem_valid,
  input  logic        iomem_ready,
  output logic [3:0]  iomem_wstrb,
  output logic [31:0] iomem_addr,
  output logic [31:0] iomem_wdata,
  input  logic [31:0] iomem_rdata,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [31:0] rd_data,
  output logic        done,
  output logic        timeout,
  output logic        busy
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TO_W  = 16;

  typedef enum logic [1:0] {S_IDLE, S_GAP, S_REQ} state_e;

  state_e      state_q, state_d;
  logic [7:0]  beats_q, beats_d;
  logic [TO_W-1:0] tcnt_q, tcnt_d;
  logic        write_q, write_d;
  logic        incr_q, incr_d;
  logic        valid_q, valid_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;
  logic        done_q, done_d;
  logic        timeout_q, timeout_d;
  logic        busy_q, busy_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        rd_valid_q, rd_valid_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic [31:0] mem_q [FIFO_DEPTH];
  logic        push, pop;

  // Next-state, bus request and FIFO bookkeeping
  always_comb begin
    state_d     = state_q;
    beats_d     = beats_q;
    tcnt_d      = tcnt_q;
    write_d     = write_q;
    incr_d      = incr_q;
    valid_d     = valid_q;
    addr_d      = addr_q;
    wstrb_d     = wstrb_q;
    wdata_d     = wdata_q;
    done_d      = 1'b0;
    timeout_d   = 1'b0;
    push        = 1'b0;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fcnt_d      = fcnt_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          write_d = cmd_write;
          incr_d  = cmd_incr;
          addr_d  = cmd_addr & 32'hFFFF_FFFC;
          wdata_d = cmd_wdata;
          // Reads carry no strobes; an all-zero write strobe means full word
          if (!cmd_write)              wstrb_d = 4'b0000;
          else if (cmd_wstrb == 4'b0000) wstrb_d = 4'b1111;
          else                         wstrb_d = cmd_wstrb;
          beats_d = cmd_count;
          tcnt_d  = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        // Reads only issue when the FIFO can take the returning word
        if (write_q || (fcnt_q < CNT_W'(FIFO_DEPTH))) begin
          valid_d = 1'b1;
          tcnt_d  = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (valid_q && iomem_ready) begin
          push    = !write_q;
          valid_d = 1'b0;
          if (incr_q) addr_d = addr_q + 32'd4;
          if (beats_q == 8'd0) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            beats_d = beats_q - 8'd1;
            state_d = S_GAP;
          end
        end else if (tcnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          valid_d   = 1'b0;
          done_d    = 1'b1;
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          tcnt_d = tcnt_q + TO_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    pop = rd_ready && rd_valid_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   fcnt_d = fcnt_q + CNT_W'(1);
      2'b01:   fcnt_d = fcnt_q - CNT_W'(1);
      default: fcnt_d = fcnt_q;
    endcase

    rd_valid_d  = (fcnt_d != '0);
    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      beats_q     <= '0;
      tcnt_q      <= '0;
      write_q     <= 1'b0;
      incr_q      <= 1'b0;
      valid_q     <= 1'b0;
      addr_q      <= '0;
      wstrb_q     <= '0;
      wdata_q     <= '0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      rd_valid_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      beats_q     <= beats_d;
      tcnt_q      <= tcnt_d;
      write_q     <= write_d;
      incr_q      <= incr_d;
      valid_q     <= valid_d;
      addr_q      <= addr_d;
      wstrb_q     <= wstrb_d;
      wdata_q     <= wdata_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
      rd_valid_q  <= rd_valid_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fcnt_q      <= fcnt_d;
    end
  end

  // FIFO storage; contents are don't-care until pointed at, so no reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= iomem_rdata;
  end

  assign cmd_ready   = cmd_ready_q;
  assign iomem_valid = valid_q;
  assign iomem_wstrb = wstrb_q;
  assign iomem_addr  = addr_q;
  assign iomem_wdata = wdata_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = mem_q[rd_ptr_q];
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign busy        = busy_q;

endmodule

// File: doc/iomem_initiator.md
# iomem_initiator

Bus-initiator engine for the SoC `iomem` interface, acting as the master end of the valid/ready protocol that the GPIO and `simplerng` responders implement. It accepts single commands of 1–256 beats, either reads or fill-writes, with a fixed or incrementing address. It drives `iomem_*` as the master and buffers read data in a small FIFO for a downstream consumer, such as an RNG harvester feeding a BRLWE datapath. A per-beat timeout keeps it from hanging on an unmapped address.

## Interface
- `TIMEOUT_CYCLES`, 255: cycles `iomem_valid` may stay high without `iomem_ready` before the command aborts (range 1–65535).
- `FIFO_DEPTH`, 4: read-data FIFO entries (power of two, ≥2).
- `clk`  in  1  single clock; all logic is on its rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  high only in IDLE; the command is accepted on `cmd_valid && cmd_ready`.
- `cmd_write`  in  1  1 = write beats, 0 = read beats.
- `cmd_addr`  in  32  first beat address; bits [1:0] are forced to 0 on the bus.
- `cmd_incr`  in  1  1 = address +4 per beat, wrapping modulo 2^32; 0 = fixed address.
- `cmd_count`  in  8  beats minus one (0 → 1 beat, 255 → 256 beats).
- `cmd_wdata`  in  32  write data, repeated on every beat.
- `cmd_wstrb`  in  4  byte strobes for writes; 4'b0000 is treated as 4'b1111.
- `iomem_valid`  out  1  registered bus request.
- `iomem_ready`  in  1  responder acknowledge.
- `iomem_wstrb`  out  4  0 for reads.
- `iomem_addr`  out  32  beat address.
- `iomem_wdata`  out  32  write data.
- `iomem_rdata`  in  32  read data, sampled in the handshake cycle.
- `rd_valid`  out  1  FIFO not empty.
- `rd_ready`  in  1  consumer pop.
- `rd_data`  out  32  FIFO head.
- `done`  out  1  one-cycle pulse when a command ends, normally or by timeout.
- `timeout`  out  1  one-cycle pulse, coincident with `done`, on abort.
- `busy`  out  1  high when not in IDLE.

## Operation
- Reset values: `iomem_valid`=0, `iomem_wstrb`=0, `iomem_addr`=0, `iomem_wdata`=0, `cmd_ready`=1, `rd_valid`=0, `done`=0, `timeout`=0, `busy`=0. The FIFO is emptied and the FSM returns to IDLE.
- **IDLE**
  - On command accept, latch all `cmd_*` fields.
  - Load the beat counter with `cmd_count` and clear the timeout counter.
  - Go to GAP. GAP is used even for the first beat, so the read-space check always applies.
- **GAP**
  - `iomem_valid`=0.
  - On a write, or a read with FIFO occupancy < `FIFO_DEPTH`: go to REQ and assert `iomem_valid` with addr/wstrb/wdata.
  - Otherwise stay in GAP; the timeout counter does not run here.
- **REQ**
  - Hold `iomem_valid`, addr, wstrb and wdata stable until the handshake.
  - Handshake (`iomem_valid && iomem_ready`):
    - On a read, push `iomem_rdata` into the FIFO.
    - `iomem_valid` drops next cycle.
    - If `cmd_incr`=1, add 4 to the address.
    - If the beat counter = 0, go to IDLE and pulse `done`. Otherwise decrement the counter and go to GAP.
  - Timeout: the counter reaches `TIMEOUT_CYCLES` without `iomem_ready`.
    - Drop `iomem_valid`, abandon the remaining beats and go to IDLE.
    - Pulse `done` and `timeout`.
    - FIFO contents are kept.
- At most one bus transaction is outstanding. There is always at least one `iomem_valid`=0 cycle between beats, which responders with a registered `iomem_ready` require.
- `iomem_ready` while `iomem_valid`=0 is ignored.
- FIFO push and pop in the same cycle leave occupancy unchanged. A pop with `rd_valid`=0 is ignored. An overflow push cannot occur, because space is checked in GAP.
- Asserting `resetn` mid-command clears `iomem_valid` asynchronously and discards FIFO data.

## Timing
- Command accept at cycle T:
  - GAP at T+1.
  - `iomem_valid` high from T+2 if space is available.
- Handshake in cycle H:
  - Read data appears as `rd_data`/`rd_valid` at H+1 if the FIFO was empty.
  - `iomem_valid` low at H+1 and high again at H+2 for the next beat.
- Minimum beat period is 2 cycles plus the responder latency.
- `done` is high in cycle H+1 after the final handshake, and `cmd_ready` returns high in that same cycle.
- Timeout: with `iomem_valid` first high in cycle V and no ready, `done`/`timeout` are high in cycle V+`TIMEOUT_CYCLES`, and `iomem_valid` is low in that cycle.

## Test plan
- Single read, addr 0x0300_1000, responder returns 0xDEADBEEF one cycle after valid:
  - `iomem_wstrb`=0.
  - `rd_data`=0xDEADBEEF.
  - `done` pulses once and `busy` returns to 0.
- Write fill, count=3, incr=1, addr 0x0300_0000, wdata 0x55, wstrb 0:
  - Four beats at 0x0300_0000/04/08/0C, each with wstrb 4'b1111.
  - At least one valid-low cycle between beats.
- Read burst of 8 with `rd_ready` held 0:
  - Exactly 4 handshakes occur, then `iomem_valid` stays 0 in GAP.
  - Popping one word lets exactly one more beat issue.
  - The 8 data words emerge in order.
- No responder (`iomem_ready` tied 0), TIMEOUT_CYCLES=16:
  - `timeout`+`done` pulse 16 cycles after valid rises.
  - Remaining beats are skipped.
  - The next command is accepted.
- Address wrap: addr 0xFFFF_FFFC, incr=1, count=1 → beats at 0xFFFF_FFFC then 0x0000_0000.
- `resetn` pulsed low mid-burst with the FIFO holding 2 words:
  - `iomem_valid` and `rd_valid` go low immediately, without a clock edge.
  - `cmd_ready`=1 after release.
